palette_lookup_engine: RTL and testbench

//  Parametrised colour-RAM/palette stage: N layer pixel codes are priority-resolved into a palette address,
//  and a pipelined palette RAM read drives video colour. CPU writes go through a small FIFO and are committed

---
 rtl/palette_pkg.sv | 42 ++++
 rtl/palette_wr_fifo.sv | 62 ++++++
 rtl/palette_lookup_engine.sv | 101 ++++++++++
 tb/tb_palette_lookup_engine.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// Shared constants and helpers for the palette lookup engine: width helpers and
// the layer priority resolver that turns N layer pixel codes into a palette address.
package palette_pkg;

  localparam int TRANSPARENT  = 0;
  localparam int MAX_LAYERS   = 16;
  localparam int MAX_PIX_W    = 16;
  localparam int MAX_PIX_BITS = MAX_LAYERS * MAX_PIX_W;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int addr_width(input int layers, input int pixW);
    return clog2(layers) + pixW;
  endfunction

  // Lowest-index opaque layer wins; with every layer transparent the backdrop
  // entry {LAYERS-1, 0} is used. Caller truncates the result to ADDR_W bits.
  function automatic logic [31:0] priority_addr(input logic [MAX_PIX_BITS-1:0] pix,
                                                input int layers, input int pixW);
    logic [31:0]          addr;
    logic [MAX_PIX_W-1:0] code;
    logic                 found;
    addr  = 32'(layers - 1) << pixW;
    found = 1'b0;
    for (int i = 0; i < MAX_LAYERS; i++) begin
      code = MAX_PIX_W'(pix >> (i * pixW)) & MAX_PIX_W'((32'd1 << pixW) - 32'd1);
      if (!found && (i < layers) && (code != MAX_PIX_W'(TRANSPARENT))) begin
        addr  = (32'(i) << pixW) | 32'(code);
        found = 1'b1;
      end
    end
    return addr;
  endfunction

endpackage

// File: rtl/palette_wr_fifo.sv
// Synchronous FIFO buffering CPU palette writes until a free RAM cycle; a push
// into a full FIFO is dropped (sticky overflow) unless a pop frees a slot that cycle.
module palette_wr_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic push_i,
  input  T     din_i,
  input  logic pop_i,
  output T     dout_o,
  output logic empty_o,
  output logic full_o,
  output logic ovf_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             doPush, doPop;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_q || doPop);

  // Pointers carry one extra bit so full and empty stay distinguishable after wrap.
  always_comb begin
    wrPtr_d = wrPtr_q + PTR_W'(doPush);
    rdPtr_d = rdPtr_q + PTR_W'(doPop);
    full_d  = ((wrPtr_d - rdPtr_d) == PTR_W'(DEPTH));
    ovf_d   = ovf_q | (push_i && !doPush);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem[wrPtr_q[IDX_W-1:0]] <= din_i;
  end

  assign dout_o = mem[rdPtr_q[IDX_W-1:0]];
  assign full_o = full_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/palette_lookup_engine.sv
// Palette stage: resolves layer priority into a palette address, reads the
// single-port palette RAM two cycles later, and commits queued CPU writes in idle RAM cycles.
module palette_lookup_engine
  import palette_pkg::*;
#(
  parameter int  LAYERS      = 2,
  parameter int  PIX_W       = 4,
  parameter int  COLOR_W     = 9,
  parameter int  WQ_DEPTH    = 4,
  parameter int  DEFER_BLANK = 0,
  localparam int LSEL_W      = clog2(LAYERS),
  localparam int ADDR_W      = LSEL_W + PIX_W
) (
  input  logic                    CLK10,
  input  logic                    RESET,
  input  logic                    PIX_CE,
  input  logic                    BLANK,
  input  logic [LAYERS*PIX_W-1:0] LAYER_PIX,
  input  logic                    CRAM_WE,
  input  logic [ADDR_W-1:0]       CRAM_ADDR,
  input  logic [COLOR_W-1:0]      CRAM_DIN,
  output logic                    CRAM_FULL,
  output logic                    CRAM_OVF,
  output logic [COLOR_W-1:0]      COLOR_OUT,
  output logic                    COLOR_VLD
);

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] data;
  } wr_req_t;

  logic [COLOR_W-1:0] ram [2**ADDR_W];

  logic [ADDR_W-1:0]  resolvedAddr;
  logic [ADDR_W-1:0]  s1Addr_q, s1Addr_d;
  logic               vS1_q, vS1_d;
  logic               vS2_q;
  logic [COLOR_W-1:0] colorOut_q;
  wr_req_t            pushReq, popReq;
  logic               fifoEmpty, fifoFull, fifoOvf;
  logic               blankOk, popEn;

  assign resolvedAddr = ADDR_W'(priority_addr(MAX_PIX_BITS'(LAYER_PIX), LAYERS, PIX_W));
  assign pushReq      = '{addr: CRAM_ADDR, data: CRAM_DIN};
  assign blankOk      = (DEFER_BLANK == 0) ? 1'b1 : BLANK;

  // A pending S1 lookup owns the RAM this cycle, so writes only commit when it is idle.
  assign popEn = !fifoEmpty && !PIX_CE && blankOk && !vS1_q && !RESET;

  palette_wr_fifo #(
    .DEPTH (WQ_DEPTH),
    .T     (wr_req_t)
  ) u_wr_fifo (
    .clk_i   (CLK10),
    .reset_i (RESET),
    .push_i  (CRAM_WE),
    .din_i   (pushReq),
    .pop_i   (popEn),
    .dout_o  (popReq),
    .empty_o (fifoEmpty),
    .full_o  (fifoFull),
    .ovf_o   (fifoOvf)
  );

  always_comb begin
    vS1_d    = PIX_CE;
    s1Addr_d = PIX_CE ? resolvedAddr : s1Addr_q;
  end

  always_ff @(posedge CLK10) begin
    if (RESET) begin
      vS1_q    <= 1'b0;
      s1Addr_q <= '0;
    end else begin
      vS1_q    <= vS1_d;
      s1Addr_q <= s1Addr_d;
    end
  end

  // COLOR_OUT holds its last value between lookups; only the valid strobe pulses.
  always_ff @(posedge CLK10) begin
    if (RESET) begin
      vS2_q      <= 1'b0;
      colorOut_q <= '0;
    end else begin
      vS2_q <= vS1_q;
      if (vS1_q) colorOut_q <= ram[s1Addr_q];
    end
  end

  always_ff @(posedge CLK10) begin
    if (popEn) ram[popReq.addr] <= popReq.data;
  end

  assign COLOR_OUT = colorOut_q;
  assign COLOR_VLD = vS2_q;
  assign CRAM_FULL = fifoFull;
  assign CRAM_OVF  = fifoOvf;

endmodule

// File: tb/tb_palette_lookup_engine.sv
// Self-checking bench for palette_lookup_engine: directed vectors and sequences
// plus randomized traffic compared against a behavioural model every cycle.
module tb_palette_lookup_engine;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       pixCe = 1'b0, blank = 1'b0, cramWe = 1'b0;
  logic [7:0] layerPix = '0;
  logic [4:0] cramAddr = '0;
  logic [8:0] cramDin = '0;
  logic       cramFull, cramOvf, colorVld;
  logic [8:0] colorOut;

  logic       dbPixCe = 1'b0, dbBlank = 1'b0, dbWe = 1'b0;
  logic [7:0] dbLayerPix = '0;
  logic [4:0] dbAddr = '0;
  logic [8:0] dbDin = '0;
  logic       dbFull, dbOvf, dbColorVld;
  logic [8:0] dbColorOut;

  int testCount = 0;
  int failCount = 0;

  palette_lookup_engine #(.LAYERS(2), .PIX_W(4), .COLOR_W(9), .WQ_DEPTH(4), .DEFER_BLANK(0)) dut (
    .CLK10(clock), .RESET(reset), .PIX_CE(pixCe), .BLANK(blank), .LAYER_PIX(layerPix),
    .CRAM_WE(cramWe), .CRAM_ADDR(cramAddr), .CRAM_DIN(cramDin), .CRAM_FULL(cramFull),
    .CRAM_OVF(cramOvf), .COLOR_OUT(colorOut), .COLOR_VLD(colorVld)
  );

  palette_lookup_engine #(.LAYERS(2), .PIX_W(4), .COLOR_W(9), .WQ_DEPTH(4), .DEFER_BLANK(1)) dutDb (
    .CLK10(clock), .RESET(reset), .PIX_CE(dbPixCe), .BLANK(dbBlank), .LAYER_PIX(dbLayerPix),
    .CRAM_WE(dbWe), .CRAM_ADDR(dbAddr), .CRAM_DIN(dbDin), .CRAM_FULL(dbFull),
    .CRAM_OVF(dbOvf), .COLOR_OUT(dbColorOut), .COLOR_VLD(dbColorVld)
  );

  // Behavioural model of the DEFER_BLANK=0 instance: RAM array, write queue, one pending lookup.
  typedef struct { logic [4:0] a; logic [8:0] d; } req_t;
  req_t       mFifo[$];
  logic [8:0] mRam [32];
  bit         mWritten [32];
  bit         mLookPending = 0;
  logic [4:0] mLookAddr = '0;
  logic [8:0] mColor = '0;
  bit         mVld = 0, mFull = 0, mOvf = 0, mColorKnown = 1;
  bit         modelOn = 1;

  function automatic logic [4:0] resolveAddr(input logic [7:0] pix);
    for (int i = 0; i < 2; i++) begin
      int code = (int'(pix) >> (i * 4)) & 15;
      if (code != 0) return 5'(i * 16 + code);
    end
    return 5'(16);
  endfunction

  function automatic logic [8:0] pat(input int a);
    return 9'((a * 37 + 5) & 511);
  endfunction

  function automatic logic [7:0] pixFor(input int a);
    if (a < 16) return 8'(a);
    return 8'((a - 16) << 4);
  endfunction

  task automatic modelStep();
    bit   readNow;
    bit   pop;
    req_t r;
    if (reset) begin
      mFifo.delete();
      mLookPending = 0;
      mColor = '0;
      mVld = 0;
      mFull = 0;
      mOvf = 0;
      mColorKnown = 1;
    end else begin
      readNow = mLookPending;
      if (readNow) begin
        mColor      = mRam[mLookAddr];
        mColorKnown = mWritten[mLookAddr];
      end
      mVld = readNow;
      pop  = (mFifo.size() > 0) && !pixCe && !readNow;
      if (pop) begin
        r = mFifo.pop_front();
        mRam[r.a]     = r.d;
        mWritten[r.a] = 1;
      end
      if (cramWe) begin
        if (mFifo.size() < 4) mFifo.push_back('{a: cramAddr, d: cramDin});
        else mOvf = 1;
      end
      mFull        = (mFifo.size() == 4);
      mLookPending = pixCe;
      if (pixCe) mLookAddr = resolveAddr(layerPix);
    end
  endtask

  always @(posedge clock) if (modelOn) modelStep();

  task automatic checkOutput(input string name, input int unsigned actual, input int unsigned expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  always @(negedge clock) begin
    if (modelOn) begin
      checkOutput("model COLOR_VLD", colorVld, mVld);
      checkOutput("model CRAM_FULL", cramFull, mFull);
      checkOutput("model CRAM_OVF", cramOvf, mOvf);
      if (mColorKnown) checkOutput("model COLOR_OUT", colorOut, mColor);
    end
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic applyStimulus(input bit db, input logic [4:0] addr, input logic [8:0] data);
    if (db) begin dbWe = 1; dbAddr = addr; dbDin = data; end
    else begin cramWe = 1; cramAddr = addr; cramDin = data; end
    step();
    if (db) dbWe = 0;
    else cramWe = 0;
  endtask

  task automatic lookupCheck(input bit db, input int a, input logic [8:0] expColor, input string name);
    if (db) begin dbPixCe = 1; dbLayerPix = pixFor(a); end
    else begin pixCe = 1; layerPix = pixFor(a); end
    step();
    if (db) dbPixCe = 0;
    else pixCe = 0;
    step();
    checkOutput({name, " vld"}, db ? dbColorVld : colorVld, 1);
    checkOutput(name, db ? dbColorOut : colorOut, expColor);
  endtask

  typedef struct { logic [7:0] pix; logic [4:0] expAddr; } vec_t;
  vec_t vecs [9];

  function automatic logic [8:0] expPre(input logic [4:0] a);
    return (a == 5'h13) ? 9'h1FF : pat(int'(a));
  endfunction

  initial begin
    vecs[0] = '{8'h35, 5'h05};
    vecs[1] = '{8'h00, 5'h10};
    vecs[2] = '{8'h30, 5'h13};
    vecs[3] = '{8'h0F, 5'h0F};
    vecs[4] = '{8'hF0, 5'h1F};
    vecs[5] = '{8'h01, 5'h01};
    vecs[6] = '{8'h10, 5'h11};
    vecs[7] = '{8'hA7, 5'h07};
    vecs[8] = '{8'hC0, 5'h1C};

    // Reset state
    step(); step();
    checkOutput("reset COLOR_VLD", colorVld, 0);
    checkOutput("reset COLOR_OUT", colorOut, 0);
    checkOutput("reset CRAM_FULL", cramFull, 0);
    checkOutput("reset CRAM_OVF", cramOvf, 0);
    checkOutput("reset db COLOR_VLD", dbColorVld, 0);
    reset = 0;
    step();

    // Deferred drain: nothing commits outside blanking, then drains in order
    applyStimulus(1, 5'h03, 9'h0AA);
    applyStimulus(1, 5'h04, 9'h0CC);
    applyStimulus(1, 5'h03, 9'h0BB);
    applyStimulus(1, 5'h05, 9'h0DD);
    checkOutput("defer full after 4", dbFull, 1);
    step(); step(); step();
    checkOutput("defer hold no blank", dbFull, 1);
    dbBlank = 1;
    step();
    checkOutput("defer drain starts", dbFull, 0);
    step(); step(); step();
    dbBlank = 0;
    checkOutput("defer no overflow", dbOvf, 0);
    lookupCheck(1, 5'h03, 9'h0BB, "defer rd 0x03");
    lookupCheck(1, 5'h04, 9'h0CC, "defer rd 0x04");
    lookupCheck(1, 5'h05, 9'h0DD, "defer rd 0x05");

    // Preload every palette entry, then entry 0x13 = 0x1FF
    for (int a = 0; a < 32; a++) applyStimulus(0, 5'(a), pat(a));
    applyStimulus(0, 5'h13, 9'h1FF);
    step(); step(); step();
    checkOutput("preload CRAM_FULL", cramFull, 0);

    // Two-cycle latency with a single-cycle valid pulse
    pixCe = 1; layerPix = 8'h30;
    step();
    pixCe = 0;
    checkOutput("latency vld at 1", colorVld, 0);
    step();
    checkOutput("latency vld at 2", colorVld, 1);
    checkOutput("latency colour", colorOut, 9'h1FF);
    step();
    checkOutput("latency vld pulse end", colorVld, 0);
    checkOutput("latency colour hold", colorOut, 9'h1FF);

    // Priority table, back-to-back lookups
    for (int i = 0; i <= 9; i++) begin
      if (i < 9) begin pixCe = 1; layerPix = vecs[i].pix; end
      else pixCe = 0;
      step();
      if (i > 0) begin
        checkOutput($sformatf("prio vld %0d", i - 1), colorVld, 1);
        checkOutput($sformatf("prio pix %02h", vecs[i-1].pix), colorOut, expPre(vecs[i-1].expAddr));
      end
    end
    step();

    // FIFO fill under continuous lookups, overflow, then drain
    pixCe = 1; layerPix = 8'h01;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 5'(2 + i), 9'(9'h100 + i));
      if (i == 3) checkOutput("fill full at 4", cramFull, 1);
    end
    checkOutput("fill overflow", cramOvf, 1);
    checkOutput("fill still full", cramFull, 1);
    pixCe = 0;
    step();
    checkOutput("read slot blocks pop", cramFull, 1);
    step();
    checkOutput("first pop frees", cramFull, 0);
    step(); step(); step();
    lookupCheck(0, 5'h02, 9'h100, "drain rd 0x02");
    lookupCheck(0, 5'h05, 9'h103, "drain rd 0x05");
    lookupCheck(0, 5'h06, pat(6), "dropped write 0x06");
    checkOutput("overflow sticky", cramOvf, 1);

    // Reset with writes queued and the pipeline busy
    pixCe = 1; layerPix = 8'h02;
    applyStimulus(0, 5'h07, 9'h0AB);
    applyStimulus(0, 5'h08, 9'h0AC);
    applyStimulus(0, 5'h09, 9'h0AD);
    reset = 1;
    step();
    checkOutput("mid reset COLOR_VLD", colorVld, 0);
    checkOutput("mid reset COLOR_OUT", colorOut, 0);
    checkOutput("mid reset CRAM_FULL", cramFull, 0);
    checkOutput("mid reset CRAM_OVF", cramOvf, 0);
    reset = 0; pixCe = 0;
    step(); step(); step(); step();
    lookupCheck(0, 5'h07, pat(7), "discarded 0x07");
    lookupCheck(0, 5'h09, pat(9), "discarded 0x09");

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      bit busy;
      busy     = ((c / 50) % 2) == 0;
      pixCe    = busy ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
      layerPix = 8'($urandom);
      blank    = 1'($urandom);
      cramWe   = ($urandom_range(0, 9) < 4);
      cramAddr = 5'($urandom);
      cramDin  = 9'($urandom);
      step();
    end
    pixCe = 0; cramWe = 0;
    step(); step(); step(); step(); step(); step();

    modelOn = 0;
    #1;
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
